// File: rtl/tsensor_reader.sv
// tsensor_reader: pulses the sensor enable, waits for the sensor's one-cycle
// valid, accumulates 1/2/4/8 readings and hands back their truncated mean
// over a valid/ready port. Sets a sticky error when the sensor stays silent.
module tsensor_reader #(
    parameter int EN_CYCLES = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_start,
    input  logic [1:0]  i_avg_log2,
    input  logic [15:0] i_period,
    input  logic        i_clr_err,
    output logic        o_sen_en,
    input  logic        i_sen_valid,
    input  logic [15:0] i_sen_data,
    output logic        o_busy,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_data,
    output logic        o_timeout
);

    // One shared cycle counter serves ARM, WAIT and GAP. It must be wide
    // enough for the enable width, the timeout and the 16-bit gap.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = $clog2(EN_CYCLES + 1);
    localparam int MW = (TW > EW) ? TW : EW;
    localparam int CW = (MW > 16) ? MW : 16;

    typedef enum logic [2:0] {IDLE, ARM, WAIT, GAP, OUT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    log2_q;
    logic [15:0]   period_q;
    logic [18:0]   acc;
    logic [3:0]    smp_cnt;
    logic [3:0]    smp_last;
    logic [18:0]   acc_sum;
    logic          smp_final;
    logic          to_hit;

    assign smp_last  = (4'd1 << log2_q) - 4'd1;
    assign acc_sum   = acc + {3'b000, i_sen_data};
    assign smp_final = (smp_cnt == smp_last);
    assign to_hit    = (cnt == CW'(TIMEOUT - 1));

    assign o_busy  = (state != IDLE);
    assign o_valid = (state == OUT);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode. A valid on the last timeout cycle still counts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = ARM;
            ARM:  if (cnt == CW'(EN_CYCLES - 1)) state_nxt = WAIT;
            WAIT: begin
                if (i_sen_valid) state_nxt = smp_final ? OUT : GAP;
                else if (to_hit) state_nxt = IDLE;
            end
            GAP:  if (cnt == CW'(period_q)) state_nxt = ARM;
            OUT:  if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sensor enable is registered and follows the ARM state exactly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) o_sen_en <= 1'b0;
        else       o_sen_en <= (state_nxt == ARM);
    end

    // Cycle counter restarts at zero on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                             cnt <= '0;
        else if (state_nxt != state)           cnt <= '0;
        else if (state inside {ARM, WAIT, GAP}) cnt <= cnt + 1'b1;
    end

    // Run configuration latch, accumulation and result capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            log2_q   <= '0;
            period_q <= '0;
            acc      <= '0;
            smp_cnt  <= '0;
            o_data   <= '0;
        end else if (state == IDLE && i_start) begin
            log2_q   <= i_avg_log2;
            period_q <= i_period;
            acc      <= '0;
            smp_cnt  <= '0;
        end else if (state == WAIT && i_sen_valid) begin
            acc     <= acc_sum;
            smp_cnt <= smp_cnt + 4'd1;
            if (smp_final) o_data <= 16'(acc_sum >> log2_q);
        end
    end

    // Sticky timeout flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                      o_timeout <= 1'b0;
        else if (state == WAIT && !i_sen_valid && to_hit) o_timeout <= 1'b1;
        else if (i_clr_err)                             o_timeout <= 1'b0;
    end

endmodule

// File: doc/tsensor_reader.md
# tsensor_reader

Sensor-side initiator for the `tsensor` block. It drives the sensor enable pulse, waits for the sensor's single-cycle valid, and captures the 16-bit reading. It accumulates 1/2/4/8 readings and returns their truncated mean through a valid/ready port. It sits between `tsensor` and the PVT register/bus logic, and flags a sticky error when the sensor never answers.

## Interface
- `EN_CYCLES`, default 4: width of the `o_sen_en` pulse in cycles (≥1).
- `TIMEOUT`, default 1023: maximum cycles to wait for `i_sen_valid` after `o_sen_en` falls (≥1).
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_avg_log2`  in  2  log2 of sample count N (0..3 → 1,2,4,8); latched at start.
- `i_period`  in  16  idle gap in cycles between consecutive conversions; latched at start.
- `i_clr_err`  in  1  clears `o_timeout`.
- `o_sen_en`  out  1  to `tsensor.en`; registered.
- `i_sen_valid`  in  1  from `tsensor.o_valid`; single-cycle pulse.
- `i_sen_data`  in  16  from `tsensor.o_data`; sampled only on `i_sen_valid`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_data`  out  16  averaged result.
- `o_timeout`  out  1  sticky no-response error.

## Operation
- States are IDLE, ARM, WAIT, GAP and OUT.
- IDLE → ARM on `i_start`.
  - On this transition: latch N and `i_period`, clear the accumulator and sample count.
- ARM: `o_sen_en`=1 for exactly EN_CYCLES cycles, then WAIT.
  - The sensor starts converting on the falling edge of en.
- WAIT: `o_sen_en`=0. The timeout counter starts at 0 on entry and increments each cycle.
  - On `i_sen_valid`: acc += `i_sen_data`, count += 1.
    - If count reaches N → OUT.
    - Otherwise → GAP.
  - If the counter reaches TIMEOUT with no valid: set `o_timeout`, go to IDLE, produce no `o_valid`, discard the partial accumulation.
- GAP: wait the latched `i_period` cycles, then ARM. A period of 0 goes to ARM on the next cycle.
- OUT: `o_valid`=1 and `o_data`=acc >> N_log2.
  - Truncating shift; acc is 19 bits unsigned, so it never overflows.
  - `o_data` holds stable until `i_ready`. When `o_valid`&&`i_ready` → IDLE.
- `i_start` outside IDLE is ignored, with no queuing.
- `i_sen_valid` outside WAIT is ignored. This includes a spurious valid during ARM.
- Valid in the same cycle the timeout counter reaches TIMEOUT: the valid wins and no error is set.
- Setting and clearing `o_timeout` in the same cycle: the set wins.
- `o_timeout` does not block new starts.
- Inputs `i_avg_log2` and `i_period` may change after start without effect on the current run.

## Timing
- Reset values: `o_sen_en`=0, `o_busy`=0, `o_valid`=0, `o_data`=0, `o_timeout`=0. State is IDLE; the accumulator and counters are 0.
- `rstn` assertion mid-operation forces the reset values asynchronously and aborts any conversion. `o_sen_en` drops immediately.
- `i_start` sampled at edge k:
  - `o_sen_en` and `o_busy` rise after edge k.
  - `o_sen_en` falls after edge k+EN_CYCLES.
- `i_sen_valid` sampled in WAIT at edge m with the final sample: `o_valid` and `o_data` are updated after edge m (1-cycle latency).
- Non-final sample at edge m: GAP for `i_period` cycles. `o_sen_en` rises again after edge m+`i_period`+1.
- Handshake sampled at edge h: `o_valid` and `o_busy` fall after edge h. The next `i_start` is accepted at edge h+1 at the earliest.
- `o_data` keeps its last value after the handshake until the next result.

## Test plan
- Basic read:
  - Stimulus: N=1, EN_CYCLES=4. The sensor model returns 0x0032 20 cycles after en falls.
  - Response: en high exactly 4 cycles, `o_valid` 1 cycle after the sensor valid, `o_data`=0x0032, `i_ready`=1 → IDLE.
- Averaging and truncation:
  - Stimulus: N=4, period=3, samples 0x0010, 0x0011, 0x0011, 0x0011.
  - Response: four en pulses, each rising 4 cycles after the prior valid; `o_data`=0x0010 (sum 67 >> 2 = 16).
- Overflow width:
  - Stimulus: N=8, all samples 0xFFFF.
  - Response: `o_data`=0xFFFF.
- Backpressure:
  - Stimulus: hold `i_ready`=0 for 10 cycles after the result.
  - Response: `o_valid` and `o_data` stable; `i_start` pulses and spurious valids are ignored; IDLE 1 cycle after `i_ready`.
- Timeout:
  - Stimulus: TIMEOUT=1023, sensor silent.
  - Response: `o_timeout`=1 exactly 1023 cycles into WAIT, no `o_valid`, `o_busy`=0.
  - Follow-up: `i_clr_err` clears it. A valid arriving on the final count instead sets no error.
- Reset mid-WAIT:
  - Stimulus: deassert `rstn` 5 cycles into WAIT.
  - Response: all outputs 0 immediately; a later sensor valid is ignored; a new start works normally.
